// File: rtl/jpeg_rgb2ycbcr.sv
// RGB to level-shifted signed YCbCr front end with two 3x64-sample block banks.
// Define JPEG_RGB2YCBCR_ROUND_EN to round half up before the coefficient shift.
module jpeg_rgb2ycbcr #(
    parameter int FRAC_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ProcessInit,
    input  logic       InEnable,
    output logic       InIdle,
    input  logic [7:0] InR,
    input  logic [7:0] InG,
    input  logic [7:0] InB,
    output logic       OutEnable,
    input  logic       OutIdle,
    output logic [1:0] OutColor,
    output logic [5:0] OutCount,
    output logic [8:0] OutData
);

    typedef enum logic [1:0] {ST_IDLE, ST_Y, ST_CB, ST_CR} state_t;

    state_t             state_q, state_d;
    logic               in_fire, out_fire, out_last, free_bank;
    logic [5:0]         wcnt_q, wcnt_d;
    logic               wbank_q, wbank_d;
    logic               rbank_q, rbank_d;
    logic [1:0]         full_q, full_d;

    logic               s1_v_q, s1_v_d;
    logic [5:0]         s1_idx_q, s1_idx_d;
    logic               s1_bank_q, s1_bank_d;
    logic [15:0]        prod_q [9];
    logic [15:0]        prod_d [9];

    logic               s2_v_q, s2_v_d;
    logic [5:0]         s2_idx_q, s2_idx_d;
    logic               s2_bank_q, s2_bank_d;
    logic signed [17:0] s2_y_q, s2_y_d;
    logic signed [17:0] s2_cb_q, s2_cb_d;
    logic signed [17:0] s2_cr_q, s2_cr_d;

    logic signed [17:0] y_adj, cb_adj, cr_adj;
    logic               wr_en;
    logic [6:0]         wr_addr;
    logic [7:0]         wr_y, wr_cb, wr_cr;
    logic [7:0]         mem_y  [128];
    logic [7:0]         mem_cb [128];
    logic [7:0]         mem_cr [128];

    logic               oen_q, oen_d;
    logic [1:0]         ocolor_q, ocolor_d;
    logic [5:0]         ocnt_q, ocnt_d;
    logic [8:0]         odata_q, odata_d;
    logic               rd_load, go_idle, rd_bank;
    logic [1:0]         rd_sel;
    logic [5:0]         rd_idx;
    logic [7:0]         rd_data;

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v > 18'sd127) begin
            return 8'h7f;
        end else if (v < -18'sd128) begin
            return 8'h80;
        end else begin
            return v[7:0];
        end
    endfunction

    assign InIdle    = ~full_q[wbank_q];
    assign in_fire   = InEnable & InIdle;
    assign out_fire  = oen_q & OutIdle;
    assign out_last  = ocnt_q == 6'd63;
    assign free_bank = (state_q == ST_CR) & out_fire & out_last;
    assign wr_en     = s2_v_q & ~ProcessInit;
    assign wr_addr   = {s2_bank_q, s2_idx_q};

    assign OutEnable = oen_q;
    assign OutColor  = ocolor_q;
    assign OutCount  = ocnt_q;
    assign OutData   = odata_q;

    // Write side: counter/bank select and the two arithmetic stages
    always_comb begin
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        if (in_fire) begin
            wcnt_d = wcnt_q + 6'd1;
            if (wcnt_q == 6'd63) begin
                wbank_d = ~wbank_q;
            end
        end
        s1_v_d    = in_fire;
        s1_idx_d  = wcnt_q;
        s1_bank_d = wbank_q;
        prod_d[0] = 16'(InR) * 16'd77;
        prod_d[1] = 16'(InG) * 16'd150;
        prod_d[2] = 16'(InB) * 16'd29;
        prod_d[3] = 16'(InR) * 16'd43;
        prod_d[4] = 16'(InG) * 16'd85;
        prod_d[5] = 16'(InB) * 16'd128;
        prod_d[6] = 16'(InR) * 16'd128;
        prod_d[7] = 16'(InG) * 16'd107;
        prod_d[8] = 16'(InB) * 16'd21;
        s2_v_d    = s1_v_q;
        s2_idx_d  = s1_idx_q;
        s2_bank_d = s1_bank_q;
        s2_y_d    = $signed({2'b00, prod_q[0]}) + $signed({2'b00, prod_q[1]})
                  + $signed({2'b00, prod_q[2]});
        s2_cb_d   = $signed({2'b00, prod_q[5]}) - $signed({2'b00, prod_q[3]})
                  - $signed({2'b00, prod_q[4]});
        s2_cr_d   = $signed({2'b00, prod_q[6]}) - $signed({2'b00, prod_q[7]})
                  - $signed({2'b00, prod_q[8]});
        full_d = full_q;
        if (free_bank) begin
            full_d[rbank_q] = 1'b0;
        end
        if (wr_en && s2_idx_q == 6'd63) begin
            full_d[s2_bank_q] = 1'b1;
        end
        if (ProcessInit) begin
            wcnt_d  = '0;
            wbank_d = 1'b0;
            s1_v_d  = 1'b0;
            s2_v_d  = 1'b0;
            full_d  = '0;
        end
    end

`ifdef JPEG_RGB2YCBCR_ROUND_EN
    localparam logic signed [17:0] RND = 18'sd1 <<< (FRAC_BITS - 1);

    always_comb begin
        y_adj  = s2_y_q + RND;
        cb_adj = s2_cb_q + RND;
        cr_adj = s2_cr_q + RND;
    end
`else
    always_comb begin
        y_adj  = s2_y_q;
        cb_adj = s2_cb_q;
        cr_adj = s2_cr_q;
    end
`endif

    assign wr_y  = sat8((y_adj >>> FRAC_BITS) - 18'sd128);
    assign wr_cb = sat8(cb_adj >>> FRAC_BITS);
    assign wr_cr = sat8(cr_adj >>> FRAC_BITS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt_q    <= '0;
            wbank_q   <= 1'b0;
            full_q    <= '0;
            s1_v_q    <= 1'b0;
            s1_idx_q  <= '0;
            s1_bank_q <= 1'b0;
            prod_q    <= '{default: '0};
            s2_v_q    <= 1'b0;
            s2_idx_q  <= '0;
            s2_bank_q <= 1'b0;
            s2_y_q    <= '0;
            s2_cb_q   <= '0;
            s2_cr_q   <= '0;
        end else begin
            wcnt_q    <= wcnt_d;
            wbank_q   <= wbank_d;
            full_q    <= full_d;
            s1_v_q    <= s1_v_d;
            s1_idx_q  <= s1_idx_d;
            s1_bank_q <= s1_bank_d;
            prod_q    <= prod_d;
            s2_v_q    <= s2_v_d;
            s2_idx_q  <= s2_idx_d;
            s2_bank_q <= s2_bank_d;
            s2_y_q    <= s2_y_d;
            s2_cb_q   <= s2_cb_d;
            s2_cr_q   <= s2_cr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_y[wr_addr]  <= wr_y;
            mem_cb[wr_addr] <= wr_cb;
            mem_cr[wr_addr] <= wr_cr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (full_q[rbank_q]) state_d = ST_Y;
            ST_Y:    if (out_fire && out_last) state_d = ST_CB;
            ST_CB:   if (out_fire && out_last) state_d = ST_CR;
            ST_CR: begin
                if (out_fire && out_last) begin
                    state_d = full_q[~rbank_q] ? ST_Y : ST_IDLE;
                end
            end
        endcase
        if (ProcessInit) begin
            state_d = ST_IDLE;
        end
    end

    // Next read address; the other bank is picked up directly after Cr 63
    always_comb begin
        rd_load = 1'b0;
        go_idle = 1'b0;
        rd_bank = rbank_q;
        rd_sel  = ocolor_q;
        rd_idx  = ocnt_q + 6'd1;
        rbank_d = rbank_q;
        unique case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    rd_load = 1'b1;
                    rd_sel  = 2'd0;
                    rd_idx  = '0;
                end
            end
            ST_Y, ST_CB: begin
                if (out_fire) begin
                    rd_load = 1'b1;
                    if (out_last) begin
                        rd_sel = ocolor_q + 2'd1;
                    end
                end
            end
            ST_CR: begin
                if (out_fire) begin
                    if (out_last) begin
                        rbank_d = ~rbank_q;
                        rd_bank = ~rbank_q;
                        rd_sel  = 2'd0;
                        rd_load = full_q[~rbank_q];
                        go_idle = ~full_q[~rbank_q];
                    end else begin
                        rd_load = 1'b1;
                    end
                end
            end
        endcase
        if (ProcessInit) begin
            rd_load = 1'b0;
            go_idle = 1'b1;
            rbank_d = 1'b0;
        end
    end

    always_comb begin
        unique case (rd_sel)
            2'd0:    rd_data = mem_y[{rd_bank, rd_idx}];
            2'd1:    rd_data = mem_cb[{rd_bank, rd_idx}];
            default: rd_data = mem_cr[{rd_bank, rd_idx}];
        endcase
    end

    always_comb begin
        oen_d    = oen_q;
        ocolor_d = ocolor_q;
        ocnt_d   = ocnt_q;
        odata_d  = odata_q;
        if (rd_load) begin
            oen_d    = 1'b1;
            ocolor_d = rd_sel;
            ocnt_d   = rd_idx;
            odata_d  = {rd_data[7], rd_data};
        end else if (go_idle) begin
            oen_d    = 1'b0;
            ocolor_d = '0;
            ocnt_d   = '0;
            odata_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oen_q    <= 1'b0;
            ocolor_q <= '0;
            ocnt_q   <= '0;
            odata_q  <= '0;
            rbank_q  <= 1'b0;
        end else begin
            oen_q    <= oen_d;
            ocolor_q <= ocolor_d;
            ocnt_q   <= ocnt_d;
            odata_q  <= odata_d;
            rbank_q  <= rbank_d;
        end
    end

endmodule

// File: tb/tb_jpeg_rgb2ycbcr.sv
// Directed bench for jpeg_rgb2ycbcr: colour-block vector table plus stall,
// ProcessInit and asynchronous reset sequences, checked against a sample queue.
`timescale 1ns/1ps
module tb_jpeg_rgb2ycbcr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ProcessInit = 1'b0;
    logic       InEnable = 1'b0;
    logic [7:0] InR = '0;
    logic [7:0] InG = '0;
    logic [7:0] InB = '0;
    logic       OutIdle = 1'b0;
    logic       InIdle;
    logic       OutEnable;
    logic [1:0] OutColor;
    logic [5:0] OutCount;
    logic [8:0] OutData;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         y;
        int         cb;
        int         cr;
    } vec_t;

    typedef struct packed {
        logic [1:0] c;
        logic [5:0] n;
        logic [8:0] d;
    } samp_t;

    int    checks = 0;
    int    errors = 0;
    int    acc_cnt = 0;
    int    oi_mode = 0;
    bit    mon_en = 1'b0;
    bit    prev_stall = 1'b0;
    int    prev_out = 0;
    samp_t exp_q[$];
    vec_t  vt[6];
    vec_t  vramp;

    jpeg_rgb2ycbcr #(.FRAC_BITS(8)) dut (
        .clk(clk),
        .rst(rst),
        .ProcessInit(ProcessInit),
        .InEnable(InEnable),
        .InIdle(InIdle),
        .InR(InR),
        .InG(InG),
        .InB(InB),
        .OutEnable(OutEnable),
        .OutIdle(OutIdle),
        .OutColor(OutColor),
        .OutCount(OutCount),
        .OutData(OutData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (oi_mode)
                0:       OutIdle = 1'b1;
                1:       OutIdle = 1'b0;
                default: OutIdle = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        samp_t e;
        if (mon_en) begin
            if (prev_stall) begin
                chk("stall_hold", int'({OutEnable, OutColor, OutCount, OutData}), prev_out);
            end
            if (OutEnable && OutIdle) begin
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", int'({OutColor, OutCount, OutData}), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("sample c%0d n%0d", e.c, e.n),
                        int'({OutColor, OutCount, OutData}), int'(e));
                end
            end
            prev_stall = OutEnable && !OutIdle;
            prev_out   = int'({OutEnable, OutColor, OutCount, OutData});
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_expect(input vec_t v, input bit ramp);
        samp_t s;
        for (int c = 0; c < 3; c++) begin
            for (int n = 0; n < 64; n++) begin
                int d;
                if (c == 0) d = ramp ? n - 128 : v.y;
                else if (c == 1) d = v.cb;
                else d = v.cr;
                s.c = 2'(c);
                s.n = 6'(n);
                s.d = 9'(d);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic send_pixel(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int t = 0;
        InEnable = 1'b1;
        InR = r;
        InG = g;
        InB = b;
        @(negedge clk);
        while (!InIdle && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!InIdle) chk("in_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        InEnable = 1'b0;
    endtask

    task automatic send_block(input vec_t v, input bit ramp, input int npix);
        for (int i = 0; i < npix; i++) begin
            if (ramp) send_pixel(8'(i), 8'(i), 8'(i));
            else send_pixel(v.r, v.g, v.b);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sample(input int c, input int n, input string name);
        int t = 0;
        @(negedge clk);
        while (!(OutEnable && OutColor == 2'(c) && OutCount == 6'(n)) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(name, (OutEnable && OutColor == 2'(c) && OutCount == 6'(n)) ? 1 : 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int gaps;
        int rise_at;
        bit seen;
        int t;

        vt[0] = '{8'd255, 8'd255, 8'd255, 127, 0, 0};
`ifdef JPEG_RGB2YCBCR_ROUND_EN
        vt[1] = '{8'd255, 8'd0, 8'd0, -51, -43, 127};
        vt[4] = '{8'd0, 8'd0, 8'd255, -99, 127, -21};
        vt[5] = '{8'd10, 8'd200, 8'd50, -2, -43, -83};
`else
        vt[1] = '{8'd255, 8'd0, 8'd0, -52, -43, 127};
        vt[4] = '{8'd0, 8'd0, 8'd255, -100, 127, -21};
        vt[5] = '{8'd10, 8'd200, 8'd50, -3, -44, -83};
`endif
        vt[2] = '{8'd0, 8'd0, 8'd0, -128, 0, 0};
        vt[3] = '{8'd0, 8'd255, 8'd0, 21, -85, -107};
        vramp = '{8'd0, 8'd0, 8'd0, 0, 0, 0};

        #2 rst = 1'b0;
        #1;
        chk("rst_InIdle", int'(InIdle), 1);
        chk("rst_OutEnable", int'(OutEnable), 0);
        chk("rst_OutColor", int'(OutColor), 0);
        chk("rst_OutCount", int'(OutCount), 0);
        chk("rst_OutData", int'(OutData), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        mon_en = 1'b1;

        oi_mode = 0;
        for (int k = 0; k < 6; k++) begin
            push_expect(vt[k], 1'b0);
            send_block(vt[k], 1'b0, 64);
            wait_drain();
        end

        // Both banks fill while the consumer is stalled
        oi_mode = 1;
        @(posedge clk);
        #2;
        base = acc_cnt;
        for (int k = 0; k < 3; k++) push_expect(vt[k], 1'b0);
        send_block(vt[0], 1'b0, 64);
        chk("inidle_after_64", int'(InIdle), 1);
        send_block(vt[1], 1'b0, 63);
        chk("inidle_after_127", int'(InIdle), 1);
        send_block(vt[1], 1'b0, 1);
        chk("inidle_after_128", int'(InIdle), 0);
        repeat (3) @(posedge clk);
        #2;
        chk("stall_no_accept", acc_cnt - base, 0);
        chk("stall_valid", int'(OutEnable), 1);
        gaps = 0;
        rise_at = -1;
        seen = 1'b0;
        fork
            send_block(vt[2], 1'b0, 64);
            begin
                oi_mode = 0;
                t = 0;
                while (t < 3000) begin
                    @(posedge clk);
                    #2;
                    if (exp_q.size() == 0) break;
                    if (!seen && InIdle) begin
                        seen = 1'b1;
                        rise_at = acc_cnt - base;
                    end
                    if (!OutEnable) gaps++;
                    t++;
                end
            end
        join
        chk("inidle_rise_samples", rise_at, 192);
        chk("b2b_gap_cycles", gaps, 0);
        wait_drain();

        oi_mode = 2;
        push_expect(vramp, 1'b1);
        push_expect(vramp, 1'b1);
        send_block(vramp, 1'b1, 64);
        send_block(vramp, 1'b1, 64);
        wait_drain();
        oi_mode = 0;
        @(posedge clk);
        #1;

        send_block(vramp, 1'b1, 30);
        ProcessInit = 1'b1;
        @(posedge clk);
        #1 ProcessInit = 1'b0;
        chk("pinit_in_OutEnable", int'(OutEnable), 0);
        chk("pinit_in_InIdle", int'(InIdle), 1);
        push_expect(vramp, 1'b1);
        send_block(vramp, 1'b1, 64);
        wait_drain();

        push_expect(vt[3], 1'b0);
        send_block(vt[3], 1'b0, 64);
        wait_sample(1, 20, "reach_cb20");
        mon_en = 1'b0;
        @(posedge clk);
        #1 ProcessInit = 1'b1;
        @(posedge clk);
        #1 ProcessInit = 1'b0;
        exp_q.delete();
        chk("pinit_out_OutEnable", int'(OutEnable), 0);
        chk("pinit_out_InIdle", int'(InIdle), 1);
        chk("pinit_out_OutCount", int'(OutCount), 0);
        mon_en = 1'b1;
        push_expect(vt[0], 1'b0);
        send_block(vt[0], 1'b0, 64);
        wait_drain();

        push_expect(vt[0], 1'b0);
        send_block(vt[0], 1'b0, 64);
        wait_sample(0, 10, "reach_y10");
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_OutEnable", int'(OutEnable), 0);
        chk("arst_OutColor", int'(OutColor), 0);
        chk("arst_OutCount", int'(OutCount), 0);
        chk("arst_OutData", int'(OutData), 0);
        chk("arst_InIdle", int'(InIdle), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        mon_en = 1'b1;
        push_expect(vt[2], 1'b0);
        send_block(vt[2], 1'b0, 64);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
